// File: rtl/me_pkg.sv
// Shared constants and FSM state type for the motion-estimator memory loader.
package me_pkg;

   localparam int RMEM_MAX = 256;   // reference block bytes (16x16)
   localparam int SMEM_MAX = 1024;  // search window bytes (32x32)
   localparam int RADDR_W  = 8;
   localparam int SADDR_W  = 10;
   localparam int CNT_W    = 10;    // wide enough for the search-window count

   typedef enum logic [2:0] {
      S_LOAD_R  = 3'd0,
      S_LOAD_S  = 3'd1,
      S_START   = 3'd2,
      S_RUN     = 3'd3,
      S_RESULT  = 3'd4
   } me_ld_state_t;

endpackage

// File: rtl/me_dual_read_ram.sv
// Byte-wide RAM with one synchronous write port and two registered read ports.
// Reads are read-before-write: a same-cycle write to the read address returns
// the previous contents. Only the read registers are reset; contents are not.
module me_dual_read_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] wrAddr,
   input  logic [7:0]    wrData,
   input  logic [AW-1:0] rdAddr1,
   input  logic [AW-1:0] rdAddr2,
   output logic [7:0]    rdData1,
   output logic [7:0]    rdData2
);

   logic [7:0] mem [DEPTH];

   // Write port: storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wrAddr] <= wrData;
      end
   end

   // Registered read ports, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdData1 <= '0;
         rdData2 <= '0;
      end else begin
         rdData1 <= mem[rdAddr1];
         rdData2 <= mem[rdAddr2];
      end
   end

endmodule

// File: rtl/me_mem_loader.sv
// Loads a reference block and a search window from a pixel stream, kicks the
// motion estimator, serves its memory reads and hands its result downstream.
//
// Handshakes: a pixel transfers on a rising edge where pix_valid && pix_ready;
// a result transfers on a rising edge where res_valid && res_ready. res_valid
// and the res_* payload stay stable until that transfer happens.
module me_mem_loader #(
   parameter int RMEM_MAX = me_pkg::RMEM_MAX,
   parameter int SMEM_MAX = me_pkg::SMEM_MAX
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_valid,
   output logic       pix_ready,
   input  logic [7:0] pix_data,
   output logic       start,
   input  logic       completed,
   input  logic [7:0] AddressR,
   input  logic [9:0] AddressS1,
   input  logic [9:0] AddressS2,
   output logic [7:0] R,
   output logic [7:0] S1,
   output logic [7:0] S2,
   input  logic [7:0] BestDist,
   input  logic [3:0] motionX,
   input  logic [3:0] motionY,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_dist,
   output logic [3:0] res_mx,
   output logic [3:0] res_my,
   output logic       busy
);

   import me_pkg::*;

   localparam logic [CNT_W-1:0] R_LAST = CNT_W'(RMEM_MAX - 1);
   localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SMEM_MAX - 1);

   me_ld_state_t     state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic             pixAccept;
   logic             capture;
   logic             rWe, sWe;
   logic [7:0]       unusedRd2;

   assign pix_ready = ((state == S_LOAD_R) || (state == S_LOAD_S)) && !rst;
   assign pixAccept = pix_valid && pix_ready;
   assign start     = (state == S_START);
   assign res_valid = (state == S_RESULT);
   assign busy      = (state == S_START) || (state == S_RUN) || (state == S_RESULT);
   assign rWe       = pixAccept && (state == S_LOAD_R);
   assign sWe       = pixAccept && (state == S_LOAD_S);

   // Next-state and counter decode; the terminal count forces the state change.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      capture   = 1'b0;
      case (state)
         S_LOAD_R: begin
            if (pixAccept) begin
               if (cnt == R_LAST) begin
                  stateNext = S_LOAD_S;
                  cntNext   = '0;
               end else begin
                  cntNext = cnt + 1'b1;
               end
            end
         end
         S_LOAD_S: begin
            if (pixAccept) begin
               if (cnt == S_LAST) begin
                  stateNext = S_START;
                  cntNext   = '0;
               end else begin
                  cntNext = cnt + 1'b1;
               end
            end
         end
         S_START: begin
            stateNext = S_RUN;
         end
         S_RUN: begin
            if (completed) begin
               capture   = 1'b1;
               stateNext = S_RESULT;
            end
         end
         S_RESULT: begin
            if (res_ready) begin
               stateNext = S_LOAD_R;
               cntNext   = '0;
            end
         end
         default: begin
            stateNext = S_LOAD_R;
            cntNext   = '0;
         end
      endcase
   end

   // State and pixel counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_LOAD_R;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // Result registers, loaded only when completed is seen in RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_dist <= '0;
         res_mx   <= '0;
         res_my   <= '0;
      end else if (capture) begin
         res_dist <= BestDist;
         res_mx   <= motionX;
         res_my   <= motionY;
      end
   end

   me_dual_read_ram #(.DEPTH(RMEM_MAX), .AW(RADDR_W)) rMem (
      .clk     (clk),
      .rst     (rst),
      .we      (rWe),
      .wrAddr  (cnt[RADDR_W-1:0]),
      .wrData  (pix_data),
      .rdAddr1 (AddressR),
      .rdAddr2 ('0),
      .rdData1 (R),
      .rdData2 (unusedRd2)
   );

   me_dual_read_ram #(.DEPTH(SMEM_MAX), .AW(SADDR_W)) sMem (
      .clk     (clk),
      .rst     (rst),
      .we      (sWe),
      .wrAddr  (cnt),
      .wrData  (pix_data),
      .rdAddr1 (AddressS1),
      .rdAddr2 (AddressS2),
      .rdData1 (S1),
      .rdData2 (S2)
   );

endmodule

// File: tb/tb_me_mem_loader.sv
// Bench for me_mem_loader: table-driven read vectors plus random streams and
// random reads checked against a flat array model of the two memories.
module tb_me_mem_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       pix_valid;
   logic       pix_ready;
   logic [7:0] pix_data;
   logic       start;
   logic       completed;
   logic [7:0] AddressR;
   logic [9:0] AddressS1;
   logic [9:0] AddressS2;
   logic [7:0] R;
   logic [7:0] S1;
   logic [7:0] S2;
   logic [7:0] BestDist;
   logic [3:0] motionX;
   logic [3:0] motionY;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_dist;
   logic [3:0] res_mx;
   logic [3:0] res_my;
   logic       busy;

   int tests = 0;
   int fails = 0;

   // Reference model: pixel n of a frame lands in R for n<256, else in S.
   logic [7:0] rModel [256];
   logic [7:0] sModel [1024];
   logic [7:0] frame  [1280];

   typedef struct {
      logic [7:0] ar;
      logic [9:0] as1;
      logic [9:0] as2;
      logic [7:0] er;
      logic [7:0] es1;
      logic [7:0] es2;
   } rd_vec_t;

   rd_vec_t vecs [6];

   me_mem_loader dut (
      .clk       (clk),
      .rst       (rst),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_data  (pix_data),
      .start     (start),
      .completed (completed),
      .AddressR  (AddressR),
      .AddressS1 (AddressS1),
      .AddressS2 (AddressS2),
      .R         (R),
      .S1        (S1),
      .S2        (S2),
      .BestDist  (BestDist),
      .motionX   (motionX),
      .motionY   (motionY),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_dist  (res_dist),
      .res_mx    (res_mx),
      .res_my    (res_my),
      .busy      (busy)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < 1280; i++) begin
         frame[i] = (i < 256) ? 8'(i) : 8'((i - 256) * 3);
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < 1280; i++) begin
         frame[i] = 8'($urandom_range(0, 255));
      end
   endtask

   // Driver: offer nPix pixels from frame[], optionally with random idle gaps.
   task automatic stream(input int nPix, input bit gaps,
                         output int cycles, output int early, output int readyLow);
      int  sent;
      bit  v;
      sent = 0; cycles = 0; early = 0; readyLow = 0;
      while (sent < nPix && cycles < 20000) begin
         v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         pix_valid = v;
         pix_data  = v ? frame[sent] : 8'($urandom_range(0, 255));
         if (!pix_ready) readyLow++;
         tick();
         cycles++;
         if (v) begin
            if (sent < 256) rModel[sent] = frame[sent];
            else            sModel[sent - 256] = frame[sent];
            sent++;
         end
         if (start && sent < nPix) early++;
      end
      pix_valid = 1'b0;
      check("stream_done_in_budget", sent, nPix);
   endtask

   task automatic read_vec(input rd_vec_t v);
      AddressR  = v.ar;
      AddressS1 = v.as1;
      AddressS2 = v.as2;
      tick();
      check("vec_R",  R,  v.er);
      check("vec_S1", S1, v.es1);
      check("vec_S2", S2, v.es2);
   endtask

   // Scoreboard for back-to-back random reads, one-cycle latency.
   task automatic rand_reads(input int n);
      logic [23:0] exp_q[$];
      logic [23:0] e;
      int ar, a1, a2;
      for (int k = 0; k < n; k++) begin
         ar = $urandom_range(0, 255);
         a1 = $urandom_range(0, 1023);
         a2 = $urandom_range(0, 1023);
         AddressR  = 8'(ar);
         AddressS1 = 10'(a1);
         AddressS2 = 10'(a2);
         exp_q.push_back({rModel[ar], sModel[a1], sModel[a2]});
         tick();
         e = exp_q.pop_front();
         check("rand_R",  R,  e[23:16]);
         check("rand_S1", S1, e[15:8]);
         check("rand_S2", S2, e[7:0]);
      end
   endtask

   task automatic full_frame(input bit gaps, input string tag);
      int cyc, early, rlow;
      stream(1280, gaps, cyc, early, rlow);
      check({tag, "_no_early_start"}, early, 0);
      check({tag, "_ready_during_load"}, rlow, 0);
      check({tag, "_start_pulse"}, start, 1);
      check({tag, "_busy_in_start"}, busy, 1);
      check({tag, "_ready_low_start"}, pix_ready, 0);
      if (!gaps) check({tag, "_min_frame_cycles"}, cyc, 1280);
   endtask

   initial begin
      int cyc, early, rlow;
      logic [7:0] bd;
      logic [3:0] mx, my;

      rst = 1'b1; pix_valid = 1'b0; pix_data = '0; completed = 1'b0;
      AddressR = '0; AddressS1 = '0; AddressS2 = '0;
      BestDist = '0; motionX = '0; motionY = '0; res_ready = 1'b0;

      vecs[0] = '{ar: 8'd200, as1: 10'd10,  as2: 10'd1023, er: 8'd200, es1: 8'd30,  es2: 8'hFD};
      vecs[1] = '{ar: 8'd0,   as1: 10'd0,   as2: 10'd1,    er: 8'd0,   es1: 8'd0,   es2: 8'd3};
      vecs[2] = '{ar: 8'd255, as1: 10'd255, as2: 10'd256,  er: 8'd255, es1: 8'd253, es2: 8'd0};
      vecs[3] = '{ar: 8'd17,  as1: 10'd85,  as2: 10'd86,   er: 8'd17,  es1: 8'd255, es2: 8'd2};
      vecs[4] = '{ar: 8'd128, as1: 10'd511, as2: 10'd1000, er: 8'd128, es1: 8'd253, es2: 8'd184};
      vecs[5] = '{ar: 8'd1,   as1: 10'd32,  as2: 10'd33,   er: 8'd1,   es1: 8'd96,  es2: 8'd99};

      // Reset values
      tick(); tick();
      check("rst_start", start, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_dist", res_dist, 0);
      check("rst_res_mx", res_mx, 0);
      check("rst_res_my", res_my, 0);
      check("rst_R", R, 0);
      check("rst_S1", S1, 0);
      check("rst_S2", S2, 0);
      check("rst_busy", busy, 0);
      check("rst_pix_ready_gated", pix_ready, 0);
      rst = 1'b0;
      #1;
      check("pix_ready_after_rst", pix_ready, 1);

      // Ramp frame, pix_valid held high
      fill_ramp();
      full_frame(1'b0, "ramp");
      tick();
      check("start_one_cycle", start, 0);
      check("run_busy", busy, 1);
      check("run_no_result", res_valid, 0);
      foreach (vecs[i]) read_vec(vecs[i]);
      check("run_still_waiting", res_valid, 0);

      // Result capture and downstream backpressure
      completed = 1'b1; BestDist = 8'h2A; motionX = 4'd3; motionY = 4'd12;
      tick();
      completed = 1'b0; BestDist = 8'hEE; motionX = 4'd1; motionY = 4'd1;
      check("res_valid_rise", res_valid, 1);
      check("res_dist", res_dist, 8'h2A);
      check("res_mx", res_mx, 3);
      check("res_my", res_my, 12);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("hold_valid", res_valid, 1);
         check("hold_payload", {res_dist, res_mx, res_my}, {8'h2A, 4'd3, 4'd12});
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("res_valid_drop", res_valid, 0);
      check("ready_after_result", pix_ready, 1);
      check("idle_after_result", busy, 0);

      // Same ramp with random gaps; completed held high through load and START
      completed = 1'b1; BestDist = 8'h11; motionX = 4'd2; motionY = 4'd2;
      full_frame(1'b1, "gapped");
      check("no_capture_before_start", res_valid, 0);
      BestDist = 8'h55; motionX = 4'd5; motionY = 4'd9;
      tick();
      check("no_capture_in_start", res_valid, 0);
      check("gapped_single_start", start, 0);
      BestDist = 8'h66; motionX = 4'd6; motionY = 4'd10;
      tick();
      completed = 1'b0;
      check("capture_first_run", res_valid, 1);
      check("capture_first_run_val", {res_dist, res_mx, res_my}, {8'h66, 4'd6, 4'd10});
      foreach (vecs[i]) read_vec(vecs[i]);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("gapped_handoff", pix_ready, 1);

      // Random data; reset while in RUN
      fill_random();
      full_frame(1'b1, "rand1");
      tick();
      rand_reads(24);
      check("rand1_in_run", busy, 1);
      rst = 1'b1;
      tick();
      check("rstrun_busy", busy, 0);
      check("rstrun_res_valid", res_valid, 0);
      check("rstrun_R", R, 0);
      check("rstrun_S1", S1, 0);
      rst = 1'b0;
      completed = 1'b1; BestDist = 8'h77; motionX = 4'd7; motionY = 4'd7;
      tick();
      completed = 1'b0;
      tick();
      check("rstrun_no_result", res_valid, 0);
      check("rstrun_idle", busy, 0);
      check("rstrun_ready", pix_ready, 1);
      rand_reads(16);

      // Reset after 700 pixels; the next load needs a whole frame
      fill_random();
      stream(700, 1'b0, cyc, early, rlow);
      check("partial_no_start", start | early, 0);
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("partial_ready_after_rst", pix_ready, 1);
      fill_random();
      full_frame(1'b1, "reload");
      tick();
      rand_reads(32);

      // Final result with random payload
      bd = 8'($urandom_range(0, 255));
      mx = 4'($urandom_range(0, 15));
      my = 4'($urandom_range(0, 15));
      completed = 1'b1; BestDist = bd; motionX = mx; motionY = my;
      tick();
      completed = 1'b0;
      check("final_valid", res_valid, 1);
      check("final_payload", {res_dist, res_mx, res_my}, {bd, mx, my});
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("final_drop", res_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
